aes_byte_sequencer: RTL and testbench

- Block-level controller for the byte-serial AES-128 core (aes_8_bit).
- Accepts one 128-bit plaintext and one 128-bit key per request over a valid/ready handshake.
- Holds the core in reset between blocks, streams 16 key/data byte pairs into it, then gathers 16 ciphertext bytes into a 128-bit result.
- Sits between the AHB slave register file and the core; it is the only driver of the core's rst, key_in and d_in.

---
 rtl/aes_byte_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_aes_byte_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_byte_sequencer.sv
// aes_byte_sequencer: drives the byte-serial AES-128 core for one block per request.
// Latency: accept + 1 core-reset + 16 load + core latency + CAPTURE_DELAY + 16 capture cycles.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   in_valid/in_ready            request handshake; in_data = plaintext, in_key = key (byte 0 = [127:120])
//   out_valid/out_ready          result handshake; out_data = ciphertext, out_err = request timed out/overran
//   busy                         high whenever a request is in flight
//   core_rst/core_key_in/core_d_in   sole drivers of the core's reset and byte inputs
//   core_data_out/core_data_valid/core_done   core result stream and completion flag
module aes_byte_sequencer #(
  parameter int unsigned CAPTURE_DELAY  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_err,
  output logic         busy,
  output logic         core_rst,
  output logic [7:0]   core_key_in,
  output logic [7:0]   core_d_in,
  input  logic [7:0]   core_data_out,
  input  logic         core_data_valid,
  input  logic         core_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_LOAD,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [1:0]  LP_DLY = 2'(CAPTURE_DELAY);
  localparam logic [15:0] LP_TO  = 16'(TIMEOUT_CYCLES);

  // Registered state
  state_t        r_state;
  logic [127:0]  r_data_sr;
  logic [127:0]  r_key_sr;
  logic          r_core_rst;
  logic [7:0]    r_core_key_in;
  logic [7:0]    r_core_d_in;
  logic          r_out_valid;
  logic          r_out_err;
  logic [127:0]  r_out_data;
  logic [3:0]    r_byte_cnt;
  logic [1:0]    r_dly_cnt;
  logic [15:0]   r_to_cnt;
  logic          r_done_q;

  // Next-state values
  state_t        w_state_nxt;
  logic [127:0]  w_data_sr_nxt;
  logic [127:0]  w_key_sr_nxt;
  logic          w_core_rst_nxt;
  logic [7:0]    w_core_key_nxt;
  logic [7:0]    w_core_d_nxt;
  logic          w_out_valid_nxt;
  logic          w_out_err_nxt;
  logic [127:0]  w_out_data_nxt;
  logic [3:0]    w_byte_cnt_nxt;
  logic [1:0]    w_dly_cnt_nxt;
  logic [15:0]   w_to_cnt_nxt;

  logic [15:0]   w_to_inc;
  logic          w_done_rise;
  logic          w_abort;
  logic          w_in_flight;

  // Saturating increment; the abort compare uses the incremented value so
  // that WAIT+CAPTURE never lasts more than TIMEOUT_CYCLES cycles.
  assign w_to_inc    = (r_to_cnt == 16'hFFFF) ? r_to_cnt : (r_to_cnt + 16'd1);
  // A completion flag rising before all 16 bytes are in means the capture
  // window was misaligned with the core; treat it like a timeout.
  assign w_done_rise = core_done & ~r_done_q;
  assign w_abort     = (w_to_inc >= LP_TO) | w_done_rise;
  assign w_in_flight = (r_state == S_WAIT) || (r_state == S_CAPTURE);

  always_comb begin
    w_state_nxt     = r_state;
    w_data_sr_nxt   = r_data_sr;
    w_key_sr_nxt    = r_key_sr;
    w_core_rst_nxt  = r_core_rst;
    w_core_key_nxt  = r_core_key_in;
    w_core_d_nxt    = r_core_d_in;
    w_out_valid_nxt = r_out_valid;
    w_out_err_nxt   = r_out_err;
    w_out_data_nxt  = r_out_data;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_dly_cnt_nxt   = r_dly_cnt;
    w_to_cnt_nxt    = r_to_cnt;

    case (r_state)
      S_IDLE: begin
        w_core_rst_nxt = 1'b1;
        w_core_key_nxt = 8'h00;
        w_core_d_nxt   = 8'h00;
        w_byte_cnt_nxt = 4'd0;
        w_dly_cnt_nxt  = 2'd0;
        w_to_cnt_nxt   = 16'd0;
        if (in_valid) begin
          w_data_sr_nxt = in_data;
          w_key_sr_nxt  = in_key;
          w_out_err_nxt = 1'b0;
          w_state_nxt   = S_CRST;
        end
      end

      S_CRST: begin
        // Release the core and present byte 0 on the same edge so the first
        // cycle the core sees rst low already carries valid data.
        w_core_rst_nxt = 1'b0;
        w_core_d_nxt   = r_data_sr[127:120];
        w_core_key_nxt = r_key_sr[127:120];
        w_data_sr_nxt  = {r_data_sr[119:0], 8'h00};
        w_key_sr_nxt   = {r_key_sr[119:0], 8'h00};
        w_byte_cnt_nxt = 4'd0;
        w_state_nxt    = S_LOAD;
      end

      S_LOAD: begin
        if (r_byte_cnt == 4'd15) begin
          w_core_d_nxt   = 8'h00;
          w_core_key_nxt = 8'h00;
          w_byte_cnt_nxt = 4'd0;
          w_to_cnt_nxt   = 16'd0;
          w_state_nxt    = S_WAIT;
        end else begin
          w_core_d_nxt   = r_data_sr[127:120];
          w_core_key_nxt = r_key_sr[127:120];
          w_data_sr_nxt  = {r_data_sr[119:0], 8'h00};
          w_key_sr_nxt   = {r_key_sr[119:0], 8'h00};
          w_byte_cnt_nxt = r_byte_cnt + 4'd1;
        end
      end

      S_WAIT: begin
        w_to_cnt_nxt = w_to_inc;
        if (core_data_valid) begin
          w_dly_cnt_nxt = LP_DLY;
          w_state_nxt   = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        w_to_cnt_nxt = w_to_inc;
        if (r_dly_cnt != 2'd0) begin
          w_dly_cnt_nxt = r_dly_cnt - 2'd1;
        end else begin
          // Sampling is free-running from here on; data_valid is not
          // re-qualified per byte.
          w_out_data_nxt = {r_out_data[119:0], core_data_out};
          w_byte_cnt_nxt = r_byte_cnt + 4'd1;
          if (r_byte_cnt == 4'd15) begin
            w_out_valid_nxt = 1'b1;
            w_core_rst_nxt  = 1'b1;
            w_state_nxt     = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_core_rst_nxt = 1'b1;
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Error exit overrides whatever WAIT/CAPTURE decided this cycle.
    if (w_in_flight && w_abort) begin
      w_out_valid_nxt = 1'b1;
      w_out_err_nxt   = 1'b1;
      w_out_data_nxt  = 128'd0;
      w_core_rst_nxt  = 1'b1;
      w_state_nxt     = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_data_sr     <= 128'd0;
      r_key_sr      <= 128'd0;
      r_core_rst    <= 1'b1;
      r_core_key_in <= 8'h00;
      r_core_d_in   <= 8'h00;
      r_out_valid   <= 1'b0;
      r_out_err     <= 1'b0;
      r_out_data    <= 128'd0;
      r_byte_cnt    <= 4'd0;
      r_dly_cnt     <= 2'd0;
      r_to_cnt      <= 16'd0;
      r_done_q      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_data_sr     <= w_data_sr_nxt;
      r_key_sr      <= w_key_sr_nxt;
      r_core_rst    <= w_core_rst_nxt;
      r_core_key_in <= w_core_key_nxt;
      r_core_d_in   <= w_core_d_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_err     <= w_out_err_nxt;
      r_out_data    <= w_out_data_nxt;
      r_byte_cnt    <= w_byte_cnt_nxt;
      r_dly_cnt     <= w_dly_cnt_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_done_q      <= core_done;
    end
  end

  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign busy        = (r_state != S_IDLE);
  assign out_valid   = r_out_valid;
  assign out_err     = r_out_err;
  assign out_data    = r_out_data;
  assign core_rst    = r_core_rst;
  assign core_key_in = r_core_key_in;
  assign core_d_in   = r_core_d_in;

endmodule

// File: tb/tb_aes_byte_sequencer.sv
// tb_aes_byte_sequencer: directed bench for aes_byte_sequencer with a stub AES core.
// The stub records the bytes loaded during LOAD, raises data_valid a fixed time later
// and streams a canned ciphertext chosen from the loaded key/plaintext.
module tb_aes_byte_sequencer;

  localparam int CD  = 2;    // CAPTURE_DELAY of the instance
  localparam int TO  = 40;   // TIMEOUT_CYCLES of the instance
  localparam int LAT = 4;    // stub cycles after LOAD before data_valid rises
  localparam int T0  = 16 + LAT;  // stub cycle index (from first LOAD cycle) of data_valid

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  // accept edge -> out_valid: CRST 1 + LOAD 16 + WAIT (LAT+1) + delay CD + capture 16
  localparam int LAT_OK      = 1 + 16 + (LAT + 1) + CD + 16;
  // accept edge -> out_valid on timeout: CRST 1 + LOAD 16 + TO
  localparam int LAT_TO      = 1 + 16 + TO;
  // overrun fires while capturing byte 5
  localparam int LAT_OVERRUN = 1 + 16 + (LAT + 1) + CD + 5 + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_err;
  logic         busy;
  logic         core_rst;
  logic [7:0]   core_key_in;
  logic [7:0]   core_d_in;
  logic [7:0]   core_data_out   = 8'h00;
  logic         core_data_valid = 1'b0;
  logic         core_done       = 1'b0;

  int errors = 0;
  int checks = 0;

  // stub core state
  int           scyc = -1;
  logic [7:0]   rec_d [16];
  logic [7:0]   rec_k [16];
  logic         stub_dv_en   = 1'b1;
  logic         stub_overrun = 1'b0;
  logic [127:0] ct_now = 128'd0;

  always #5 clk = ~clk;

  aes_byte_sequencer #(
    .CAPTURE_DELAY  (CD),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_key          (in_key),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_err         (out_err),
    .busy            (busy),
    .core_rst        (core_rst),
    .core_key_in     (core_key_in),
    .core_d_in       (core_d_in),
    .core_data_out   (core_data_out),
    .core_data_valid (core_data_valid),
    .core_done       (core_done)
  );

  // Stub core: updates mid-cycle so values are stable at the next rising edge.
  // Byte k appears CD+1+k cycles after the data_valid cycle.
  always @(negedge clk) begin
    logic [127:0] sh;
    logic         all_zero;
    int           k;
    if (core_rst) begin
      scyc            = -1;
      core_data_valid = 1'b0;
      core_data_out   = 8'h00;
      core_done       = 1'b0;
    end else begin
      scyc = scyc + 1;
      if (scyc < 16) begin
        rec_d[scyc] = core_d_in;
        rec_k[scyc] = core_key_in;
      end
      if (scyc == 15) begin
        all_zero = 1'b1;
        for (int i = 0; i < 16; i++)
          if (rec_d[i] != 8'h00 || rec_k[i] != 8'h00) all_zero = 1'b0;
        ct_now = all_zero ? ZERO_CT : C1_CT;
      end
      core_data_valid = stub_dv_en && (scyc >= T0) && (scyc < T0 + 16);
      k = scyc - (T0 + 1 + CD);
      if (stub_dv_en && k >= 0 && k < 16) begin
        sh = ct_now << (8 * k);
        core_data_out = sh[127:120];
      end else begin
        core_data_out = 8'h00;
      end
      if (stub_overrun && k == 5) core_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return once the accept edge has passed.
  task automatic send_req(input logic [127:0] d, input logic [127:0] k);
    int waited;
    waited   = 0;
    in_data  = d;
    in_key   = k;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Edges from the accept edge until out_valid is seen; -1 if it never comes.
  task automatic wait_out(output int n);
    n = 1;
    tick();
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    if (!out_valid) n = -1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = C1_PT;
    in_key    = C1_KEY;
    out_ready = 1'b0;
    repeat (3) tick();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
    checks++; if (core_key_in !== 8'h00) begin errors++; $display("FAIL reset_key_in: got %h want 00", core_key_in); end
    checks++; if (core_d_in !== 8'h00) begin errors++; $display("FAIL reset_d_in: got %h want 00", core_d_in); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_c1();
    int n;
    logic [127:0] got_d;
    logic [127:0] got_k;
    out_ready = 1'b1;
    send_req(C1_PT, C1_KEY);
    wait_out(n);
    checks++; if (n != LAT_OK) begin errors++; $display("FAIL c1_latency: got %0d want %0d", n, LAT_OK); end
    checks++; if (out_data !== C1_CT) begin errors++; $display("FAIL c1_data: got %h want %h", out_data, C1_CT); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL c1_err: got %b want 0", out_err); end
    got_d = '0;
    got_k = '0;
    for (int i = 0; i < 16; i++) begin
      got_d = {got_d[119:0], rec_d[i]};
      got_k = {got_k[119:0], rec_k[i]};
    end
    checks++; if (got_d !== C1_PT) begin errors++; $display("FAIL c1_d_in_seq: got %h want %h", got_d, C1_PT); end
    checks++; if (got_k !== C1_KEY) begin errors++; $display("FAIL c1_key_in_seq: got %h want %h", got_k, C1_KEY); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL c1_valid_drop: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL c1_idle_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int acc0, acc1, hs0, hs1;
    logic a, h;
    logic [127:0] res0, res1;
    acc0 = -1; acc1 = -1; hs0 = -1; hs1 = -1;
    res0 = '0; res1 = '0;
    out_ready = 1'b1;
    in_data   = C1_PT;
    in_key    = C1_KEY;
    in_valid  = 1'b1;
    for (int c = 0; c < 300 && hs1 < 0; c++) begin
      a = in_valid && in_ready;
      h = out_valid && out_ready;
      if (h) begin
        if (hs0 < 0) begin hs0 = c; res0 = out_data; end
        else begin hs1 = c; res1 = out_data; end
      end
      tick();
      if (a) begin
        if (acc0 < 0) begin
          acc0    = c;
          in_data = '0;   // second request; also shows the first was latched
          in_key  = '0;
        end else begin
          acc1     = c;
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (hs0 < 0 || acc1 != hs0 + 1) begin errors++; $display("FAIL b2b_second_accept: got cycle %0d want %0d", acc1, hs0 + 1); end
    checks++; if (acc0 != 0) begin errors++; $display("FAIL b2b_first_accept: got cycle %0d want 0", acc0); end
    checks++; if (res0 !== C1_CT) begin errors++; $display("FAIL b2b_res0: got %h want %h", res0, C1_CT); end
    checks++; if (res1 !== ZERO_CT) begin errors++; $display("FAIL b2b_res1: got %h want %h", res1, ZERO_CT); end
    tick();
  endtask

  task automatic test_backpressure();
    int n, bad;
    logic [127:0] held;
    out_ready = 1'b0;
    send_req(C1_PT, C1_KEY);
    wait_out(n);
    checks++; if (n != LAT_OK) begin errors++; $display("FAIL bp_latency: got %0d want %0d", n, LAT_OK); end
    held = out_data;
    bad  = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    checks++; if (held !== C1_CT) begin errors++; $display("FAIL bp_data: got %h want %h", held, C1_CT); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    stub_dv_en = 1'b0;
    out_ready  = 1'b1;
    send_req(C1_PT, C1_KEY);
    wait_out(n);
    checks++; if (n != LAT_TO) begin errors++; $display("FAIL to_latency: got %0d want %0d", n, LAT_TO); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", out_err); end
    checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL to_data: got %h want 0", out_data); end
    tick();
    stub_dv_en = 1'b1;
  endtask

  task automatic test_overrun();
    int n;
    stub_overrun = 1'b1;
    out_ready    = 1'b1;
    send_req(C1_PT, C1_KEY);
    wait_out(n);
    checks++; if (n != LAT_OVERRUN) begin errors++; $display("FAIL ovr_latency: got %0d want %0d", n, LAT_OVERRUN); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL ovr_err: got %b want 1", out_err); end
    checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL ovr_data: got %h want 0", out_data); end
    tick();
    stub_overrun = 1'b0;
  endtask

  task automatic test_mid_reset();
    int n, seen;
    out_ready = 1'b1;
    send_req(C1_PT, C1_KEY);
    repeat (8) tick();  // now in LOAD byte 7
    checks++; if (core_d_in !== 8'h77 || core_key_in !== 8'h07) begin
      errors++; $display("FAIL mr_byte7: got d=%h k=%h want 77 07", core_d_in, core_key_in);
    end
    rst = 1'b1;
    tick();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL mr_core_rst: got %b want 1", core_rst); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mr_state: got busy=%b ready=%b want 0 0", busy, in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_ready: got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mr_no_output: got %0d valid cycles want 0", seen); end
    send_req(C1_PT, C1_KEY);
    wait_out(n);
    checks++; if (n != LAT_OK) begin errors++; $display("FAIL mr_latency: got %0d want %0d", n, LAT_OK); end
    checks++; if (out_data !== C1_CT) begin errors++; $display("FAIL mr_data: got %h want %h", out_data, C1_CT); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL mr_err: got %b want 0", out_err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_c1();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_overrun();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
